// File: rtl/fifo_reader.sv
// fifo_reader: read-side drain engine for the fifo block.
// Issues FIFO reads, absorbs the FIFO's one-cycle read latency through a
// 3-entry skid buffer, and presents the words as a valid/ready stream.
// rd_en never depends on m_ready, so no combinational path crosses the block.

module fifo_reader #(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  idle
);

    localparam int DEPTH = 3;

    logic [1:0]            occ_q,      occ_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            wr_ptr_q,   wr_ptr_d;
    logic [1:0]            rd_ptr_q,   rd_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic [FIFO_WIDTH-1:0] buf_q [DEPTH];

    logic [2:0] pending;
    logic       capture;
    logic       transfer;

    // Circular pointer over 3 entries: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already owned by this block: buffered plus the one returning now.
    assign pending  = {1'b0, occ_q} + {2'b00, inflight_q};

    // Read only when a free slot is guaranteed for the returning word.
    assign rd_en    = !rst && enable && !empty && (pending < 3'd3);

    assign capture  = inflight_q;
    assign m_valid  = (occ_q != 2'd0);
    assign transfer = m_valid && m_ready;
    assign m_data   = buf_q[rd_ptr_q];
    assign rd_count = rd_count_q;
    assign idle     = (occ_q == 2'd0) && !inflight_q;

    // Next-state for occupancy, in-flight flag, pointers and delivered count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        occ_d      = occ_q;
        inflight_d = rd_en;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_count_d = rd_count_q;

        if (capture) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (transfer) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end
        // Capture and pop in the same cycle cancel; 3 is never exceeded
        // because rd_en reserves the slot in advance.
        occ_d = occ_q + {1'b0, capture} - {1'b0, transfer};
    end

    // Control state register with synchronous reset; an in-flight word is dropped.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            rd_count_q <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Skid buffer storage: writes the returning FIFO word into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: the data array is left out of reset on purpose; occ gates
        // every read of it, so stale contents are never observed.
        if (capture) begin
            buf_q[wr_ptr_q] <= data_out;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader with a behavioural FIFO
// (one-cycle registered read) and a second instance with a 4-bit counter.

module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       m_ready;
    logic       empty;
    logic [7:0] data_out;

    logic       rd_en, m_valid, idle;
    logic [7:0] m_data;
    logic [15:0] rd_count;

    logic       rd_en_w4, m_valid_w4, idle_w4;
    logic [7:0] m_data_w4;
    logic [3:0] rd_count_w4;

    // Behavioural FIFO controls driven by the tests
    logic       wr_en_t;
    logic [7:0] wr_data_t;
    logic       flush_t;
    logic [7:0] fq [$];

    int checks   = 0;
    int failures = 0;

    // Monitor bookkeeping (written only by the monitor)
    int         cyc_n     = 0;
    int         got_n     = 0;
    int         rd_pulses = 0;
    int         viol      = 0;
    logic [7:0] got_data [0:255];
    int         got_cyc  [0:255];

    always #5 clk = ~clk;

    fifo_reader #(.FIFO_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .empty(empty), .data_out(data_out),
        .rd_en(rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .rd_count(rd_count), .idle(idle)
    );

    // Same stimulus, narrow counter; its rd_en mirrors the main instance.
    fifo_reader #(.FIFO_WIDTH(8), .CNT_WIDTH(4)) u_dut_w4 (
        .clk(clk), .rst(rst), .enable(enable), .empty(empty), .data_out(data_out),
        .rd_en(rd_en_w4), .m_valid(m_valid_w4), .m_ready(m_ready), .m_data(m_data_w4),
        .rd_count(rd_count_w4), .idle(idle_w4)
    );

    // FIFO model: registered read data, flag updated on the clock edge.
    always @(posedge clk) begin
        if (flush_t) begin
            fq.delete();
        end else begin
            if (rd_en && fq.size() != 0) data_out <= fq.pop_front();
            if (wr_en_t) fq.push_back(wr_data_t);
        end
        empty <= (fq.size() == 0);
    end

    // Stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (!rst) begin
            if (rd_en) rd_pulses <= rd_pulses + 1;
            if (rd_en && empty) viol <= viol + 1;
            if (m_valid && m_ready) begin
                got_data[got_n[7:0]] <= m_data;
                got_cyc[got_n[7:0]]  <= cyc_n;
                got_n <= got_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            next();
            wr_en_t   = 1'b1;
            wr_data_t = first + 8'(i);
        end
        next();
        wr_en_t = 1'b0;
    endtask

    task automatic do_reset();
        next();
        rst = 1'b1; flush_t = 1'b1; enable = 1'b0; m_ready = 1'b0; wr_en_t = 1'b0;
        next();
        next();
        rst = 1'b0; flush_t = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1; flush_t = 1'b1;
        wr_en_t = 1'b0; wr_data_t = 8'h00;
        next();
        flush_t = 1'b0;
        fill(4, 8'hA0);
        next(); next(); next(); #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle); end
        next(); rst = 1'b0; #1;
        checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL release_first_rd_en: got %b expected 1", rd_en); end
        next(); #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL latency_n1_m_valid: got %b expected 0", m_valid); end
        next(); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA0) begin failures++; $display("FAIL latency_n2_word: got valid=%b data=%h expected valid=1 data=a0", m_valid, m_data); end
        repeat (8) next(); #1;
        checks++; if (rd_count !== 16'd4 || idle !== 1'b1) begin failures++; $display("FAIL reset_drain: got count=%0d idle=%b expected count=4 idle=1", rd_count, idle); end
    endtask

    task automatic test_streaming();
        int b, p0, v0, gaps;
        do_reset();
        m_ready = 1'b1;
        fill(16, 8'h01);
        b = got_n; p0 = rd_pulses; v0 = viol;
        enable = 1'b1;
        repeat (30) next(); #1;
        checks++; if (got_n - b != 16) begin failures++; $display("FAIL stream_count: got %0d expected 16", got_n - b); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_data[b + i] !== 8'(i + 1)) begin failures++; $display("FAIL stream_word%0d: got %h expected %h", i, got_data[b + i], 8'(i + 1)); end
        end
        gaps = 0;
        for (int i = 1; i < 16; i++) if (got_cyc[b + i] != got_cyc[b + i - 1] + 1) gaps++;
        checks++; if (gaps != 0) begin failures++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
        checks++; if (rd_count !== 16'd16 || idle !== 1'b1) begin failures++; $display("FAIL stream_end: got count=%0d idle=%b expected count=16 idle=1", rd_count, idle); end
        checks++; if (viol - v0 != 0) begin failures++; $display("FAIL stream_rd_en_when_empty: got %0d expected 0", viol - v0); end
        checks++; if (rd_pulses - p0 != 16) begin failures++; $display("FAIL stream_rd_pulses: got %0d expected 16", rd_pulses - p0); end
    endtask

    task automatic test_backpressure();
        int b, p0, unstable, gaps;
        do_reset();
        fill(8, 8'h01);
        b = got_n; p0 = rd_pulses; unstable = 0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next(); #1;
            if (m_valid && m_data !== 8'h01) unstable++;
        end
        checks++; if (rd_pulses - p0 != 3) begin failures++; $display("FAIL bp_rd_pulses: got %0d expected 3", rd_pulses - p0); end
        checks++; if (u_dut.occ_q !== 2'd3) begin failures++; $display("FAIL bp_occ: got %0d expected 3", u_dut.occ_q); end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h01 || unstable != 0) begin failures++; $display("FAIL bp_hold: got valid=%b data=%h unstable=%0d expected valid=1 data=01 unstable=0", m_valid, m_data, unstable); end
        next(); m_ready = 1'b1; #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL bp_restart_cycle0: got %b expected 0", rd_en); end
        next(); #1;
        checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL bp_restart_cycle1: got %b expected 1", rd_en); end
        repeat (15) next(); #1;
        checks++; if (got_n - b != 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", got_n - b); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data[b + i] !== 8'(i + 1)) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", i, got_data[b + i], 8'(i + 1)); end
        end
        gaps = 0;
        for (int i = 1; i < 8; i++) if (got_cyc[b + i] != got_cyc[b + i - 1] + 1) gaps++;
        checks++; if (gaps != 0) begin failures++; $display("FAIL bp_gaps: got %0d expected 0", gaps); end
        checks++; if (rd_count !== 16'd8) begin failures++; $display("FAIL bp_rd_count: got %0d expected 8", rd_count); end
    endtask

    task automatic test_enable_gating();
        int b, p0;
        do_reset();
        m_ready = 1'b1;
        fill(4, 8'h31);
        b = got_n; p0 = rd_pulses;
        next(); enable = 1'b1;
        next();
        next(); enable = 1'b0; #1;
        checks++; if (rd_en !== 1'b0 || u_dut.inflight_q !== 1'b1) begin failures++; $display("FAIL gate_inflight: got rd_en=%b inflight=%b expected rd_en=0 inflight=1", rd_en, u_dut.inflight_q); end
        repeat (8) next(); #1;
        checks++; if (rd_pulses - p0 != 2) begin failures++; $display("FAIL gate_rd_pulses: got %0d expected 2", rd_pulses - p0); end
        checks++; if (got_n - b != 2 || got_data[b] !== 8'h31 || got_data[b + 1] !== 8'h32) begin failures++; $display("FAIL gate_words: got n=%0d %h %h expected n=2 31 32", got_n - b, got_data[b], got_data[b + 1]); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL gate_idle: got %b expected 1", idle); end
        enable = 1'b1;
        repeat (10) next(); #1;
        checks++; if (got_n - b != 4 || got_data[b + 2] !== 8'h33 || got_data[b + 3] !== 8'h34) begin failures++; $display("FAIL gate_resume: got n=%0d %h %h expected n=4 33 34", got_n - b, got_data[b + 2], got_data[b + 3]); end
        checks++; if (rd_count !== 16'd4) begin failures++; $display("FAIL gate_rd_count: got %0d expected 4", rd_count); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        m_ready = 1'b1;
        fill(18, 8'h40);
        enable = 1'b1;
        repeat (30) next(); #1;
        checks++; if (rd_count !== 16'd18) begin failures++; $display("FAIL wrap_wide_count: got %0d expected 18", rd_count); end
        checks++; if (rd_count_w4 !== 4'd2) begin failures++; $display("FAIL wrap_narrow_count: got %0d expected 2", rd_count_w4); end
        checks++; if (idle_w4 !== 1'b1 || m_valid_w4 !== 1'b0) begin failures++; $display("FAIL wrap_narrow_idle: got idle=%b valid=%b expected idle=1 valid=0", idle_w4, m_valid_w4); end
    endtask

    task automatic test_reset_midstream();
        int b;
        enable = 1'b0; m_ready = 1'b0;
        fill(5, 8'h51);
        enable = 1'b1;
        next(); next(); next(); #1;
        checks++; if (u_dut.occ_q !== 2'd2 || u_dut.inflight_q !== 1'b1 || rd_count !== 16'd18) begin failures++; $display("FAIL mid_setup: got occ=%0d inflight=%b count=%0d expected occ=2 inflight=1 count=18", u_dut.occ_q, u_dut.inflight_q, rd_count); end
        rst = 1'b1; flush_t = 1'b1; #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en_in_reset: got %b expected 0", rd_en); end
        next(); rst = 1'b0; flush_t = 1'b0; #1;
        checks++; if (m_valid !== 1'b0 || rd_count !== 16'd0 || idle !== 1'b1) begin failures++; $display("FAIL mid_after_reset: got valid=%b count=%0d idle=%b expected valid=0 count=0 idle=1", m_valid, rd_count, idle); end
        b = got_n;
        m_ready = 1'b1;
        fill(2, 8'h61);
        repeat (10) next(); #1;
        checks++; if (got_n - b != 2 || got_data[b] !== 8'h61 || got_data[b + 1] !== 8'h62) begin failures++; $display("FAIL mid_no_stale: got n=%0d %h %h expected n=2 61 62", got_n - b, got_data[b], got_data[b + 1]); end
        checks++; if (rd_count !== 16'd2) begin failures++; $display("FAIL mid_rd_count: got %0d expected 2", rd_count); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_enable_gating();
        test_counter_wrap();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
